// File: rtl/pc_gen_ras_if.sv
// Purpose : fetch-PC generator bundle (redirect/stall/predecode inputs, PC/RAS outputs).
// Latency : n/a (signal bundle only).
// Backpressure: StallF_i holds the PC; there is no ready/valid handshake.
// Ports   : slave modport = PC generator side, master modport = pipeline/driver side.
interface pc_gen_ras_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
);
  logic                        StallF_i;
  logic                        TrapE_i;
  logic                        PCsrcE_i;
  logic [DATA_WIDTH-1:0]       PCTargetE_i;
  logic                        CallF_i;
  logic [DATA_WIDTH-1:0]       CallTargetF_i;
  logic                        RetF_i;
  logic [DATA_WIDTH-1:0]       PC_o;
  logic [DATA_WIDTH-1:0]       PCPlusF_o;
  logic                        RasHitF_o;
  logic [$clog2(RAS_DEPTH):0]  RasCount_o;

  modport master (
    output StallF_i, TrapE_i, PCsrcE_i, PCTargetE_i, CallF_i, CallTargetF_i, RetF_i,
    input  PC_o, PCPlusF_o, RasHitF_o, RasCount_o
  );

  modport slave (
    input  StallF_i, TrapE_i, PCsrcE_i, PCTargetE_i, CallF_i, CallTargetF_i, RetF_i,
    output PC_o, PCPlusF_o, RasHitF_o, RasCount_o
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Purpose : fetch PC generator with trap/branch redirect, stall and a circular return-address stack.
// Latency : next PC chosen combinationally, PC_o registered (1 cycle); PCPlusF_o/RasHitF_o combinational.
// Backpressure: StallF_i holds PC and RAS; redirects (trap, Execute) override a stall.
// Ports   : clk, rst (sync, active-high); bus (pc_gen_ras_if.slave) carries StallF_i, TrapE_i,
//           PCsrcE_i, PCTargetE_i, CallF_i, CallTargetF_i, RetF_i in and PC_o, PCPlusF_o,
//           RasHitF_o, RasCount_o out.
module pc_gen_ras #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC   = 32'hBFC00380,
  parameter int                    PC_INC     = 4,
  parameter int                    RAS_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  pc_gen_ras_if.slave  bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic                  ras_we;
  logic [PTR_W-1:0]      ras_widx;
  logic                  hit;

  // Modulo-2^DATA_WIDTH increment; wrap is silent by design.
  assign pc_plus = pc_q + DATA_WIDTH'(PC_INC);

  always_comb begin
    pc_d     = pc_plus;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    hit      = 1'b0;
    if (bus.TrapE_i) begin
      // Trap flushes the prediction state; stale entries are masked by count=0.
      pc_d  = TRAP_VEC;
      cnt_d = '0;
    end else if (bus.PCsrcE_i) begin
      pc_d = bus.PCTargetE_i;
    end else if (bus.StallF_i) begin
      pc_d = pc_q;
    end else if (bus.RetF_i && bus.CallF_i) begin
      // Coroutine swap: replace top in place rather than pop+push.
      pc_d     = bus.CallTargetF_i;
      ras_we   = 1'b1;
      ras_widx = ptr_q;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (bus.RetF_i) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[ptr_q];
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
        hit   = 1'b1;
      end
    end else if (bus.CallF_i) begin
      // Pointer wraps, so a push on a full stack overwrites the oldest entry.
      pc_d     = bus.CallTargetF_i;
      ptr_d    = ptr_q + PTR_W'(1);
      ras_we   = 1'b1;
      ras_widx = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  // Entry storage needs no reset: contents are only read when count > 0.
  always_ff @(posedge clk) begin
    if (!rst && ras_we) begin
      ras_q[ras_widx] <= pc_plus;
    end
  end

  assign bus.PC_o       = pc_q;
  assign bus.PCPlusF_o  = pc_plus;
  assign bus.RasHitF_o  = hit & ~rst;
  assign bus.RasCount_o = cnt_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] TRAPV  = 32'hBFC00380;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_ras_if #(.DATA_WIDTH(32), .RAS_DEPTH(DEPTH)) bus ();

  pc_gen_ras #(
    .DATA_WIDTH(32), .RESET_PC(RST_PC), .TRAP_VEC(TRAPV), .PC_INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp;
    logic [2:0]  cnt;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];   // back = top of stack, size = valid count
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a new PC; check it against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PC_o",       bus.PC_o,                e.pc);
        chk("PCPlusF_o",  bus.PCPlusF_o,           e.pcp);
        chk("RasCount_o", 32'(bus.RasCount_o),     32'(e.cnt));
        chk("RasHitF_o",  32'(bus.RasHitF_o),      32'(e.hit));
      end
    end
  end

  // Drive one cycle of inputs, record what the outputs must show this cycle,
  // then advance the reference model to the next cycle.
  task automatic step(input logic r, input logic st, input logic tr, input logic ps,
                      input logic [31:0] pt, input logic ca, input logic [31:0] ct,
                      input logic re);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.StallF_i      = st;
    bus.TrapE_i       = tr;
    bus.PCsrcE_i      = ps;
    bus.PCTargetE_i   = pt;
    bus.CallF_i       = ca;
    bus.CallTargetF_i = ct;
    bus.RetF_i        = re;
    e.pc  = m_pc;
    e.pcp = m_pc + 32'd4;
    e.cnt = 3'(m_ras.size());
    e.hit = 1'b0;
    if (r) begin
      m_pc = RST_PC;
      m_ras.delete();
    end else if (tr) begin
      m_pc = TRAPV;
      m_ras.delete();
    end else if (ps) begin
      m_pc = pt;
    end else if (st) begin
      m_pc = m_pc;
    end else if (re && ca) begin
      if (m_ras.size() == 0) m_ras.push_back(e.pcp);
      else m_ras[m_ras.size()-1] = e.pcp;
      m_pc = ct;
    end else if (re) begin
      if (m_ras.size() > 0) begin
        m_pc  = m_ras.pop_back();
        e.hit = 1'b1;
      end else begin
        m_pc = e.pcp;
      end
    end else if (ca) begin
      m_ras.push_back(e.pcp);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      m_pc = ct;
    end else begin
      m_pc = e.pcp;
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask
  task automatic jump(input logic [31:0] t);
    step(0, 0, 0, 1, t, 0, 32'h0, 0);
  endtask
  task automatic call(input logic [31:0] t);
    step(0, 0, 0, 0, 32'h0, 1, t, 0);
  endtask
  task automatic ret();
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  initial begin
    bus.StallF_i = 0; bus.TrapE_i = 0; bus.PCsrcE_i = 0; bus.PCTargetE_i = 0;
    bus.CallF_i = 0; bus.CallTargetF_i = 0; bus.RetF_i = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    m_pc = RST_PC;
    m_ras.delete();

    // Free-run from reset, then stall twice and redirect while stalled.
    idle(); idle();
    step(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 1, 32'hBFC00100, 0, 32'h0, 0);
    idle();

    // Call at 0x1000 -> 0x2000, return at 0x2010 -> 0x1004.
    jump(32'h1000);
    call(32'h2000);
    repeat (4) idle();
    ret();
    idle();

    // Five nested calls overflow a 4-deep stack; fifth return misses.
    jump(32'h100);
    call(32'h200); call(32'h300); call(32'h400); call(32'h500); call(32'h600);
    repeat (5) ret();
    idle();

    // Trap beats branch and call with three entries live.
    jump(32'h40);
    call(32'h80); call(32'hC0); call(32'h100);
    step(0, 0, 1, 1, 32'h1234, 1, 32'h5678, 0);
    idle();

    // Coroutine swap on empty and non-empty stack.
    step(0, 0, 0, 0, 32'h0, 1, 32'h3000, 1);
    call(32'h4000);
    step(0, 0, 0, 0, 32'h0, 1, 32'h5000, 1);
    ret(); ret(); ret();

    // Address wrap.
    jump(32'hFFFFFFFC);
    idle(); idle();

    // Mid-operation reset with two entries live.
    call(32'h700); call(32'h800);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    idle(); idle();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pt, ct;
      pt = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC};
      ct = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC};
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0,
           pt,
           $urandom_range(0, 2) == 0,
           ct,
           $urandom_range(0, 2) == 0);
    end
    idle();

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised fetch-stage program-counter generator, successor to the single-mux PC register.
- Adds fetch stall, prioritised redirect sources (trap, execute-stage branch/jump), and fetch-time call/return prediction through a circular return-address stack (RAS) of configurable depth.
- Sits at the front of the 5-stage pipeline. It drives the fetch address to instruction memory and takes redirects from Execute and from the hazard unit.

Parameters:
- DATA_WIDTH, 32, width of PC and all address ports.
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- TRAP_VEC, 32'hBFC00380, PC loaded on trap redirect.
- PC_INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries. Must be ≥2 and a power of two.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- StallF_i  input  1  hazard-unit stall: hold PC, ignore call/ret.
- TrapE_i  input  1  trap/exception redirect to TRAP_VEC.
- PCsrcE_i  input  1  Execute-stage taken branch/jump redirect.
- PCTargetE_i  input  DATA_WIDTH  redirect target from Execute.
- CallF_i  input  1  predecoded call (jal/jalr with rd=x1/x5) at PC_o.
- CallTargetF_i  input  DATA_WIDTH  predecoded call target.
- RetF_i  input  1  predecoded return (jalr x0, 0(x1/x5)) at PC_o.
- PC_o  output  DATA_WIDTH  current fetch PC, registered.
- PCPlusF_o  output  DATA_WIDTH  PC_o + PC_INC, combinational.
- RasHitF_o  output  1  return this cycle predicted from RAS, combinational.
- RasCount_o  output  $clog2(RAS_DEPTH)+1  valid RAS entries, registered.

Behaviour:
- Reset (synchronous, active-high):
  - PC_o = RESET_PC; RAS count = 0; RAS top pointer = 0.
  - RAS entry contents are don't-care.
  - Reset overrides every other input in the same cycle.
- Latency: next-PC selection is combinational; PC_o updates one cycle later. No bubbles are inserted by the block.
- Next-PC priority, highest first:
  1. TrapE_i → TRAP_VEC; RAS count cleared to 0.
  2. PCsrcE_i → PCTargetE_i; RAS unchanged; CallF_i/RetF_i ignored as wrong-path.
  3. StallF_i → PC_o held; RAS unchanged; CallF_i/RetF_i ignored.
  4. RetF_i && CallF_i (coroutine swap) → CallTargetF_i. Top entry is replaced by PCPlusF_o; count is unchanged if nonzero, otherwise becomes 1.
  5. RetF_i && count>0 → top entry; pop (count−1, pointer−1 mod RAS_DEPTH); RasHitF_o=1.
  6. RetF_i && count==0 → PCPlusF_o; no pop; RasHitF_o=0. Execute corrects later.
  7. CallF_i → CallTargetF_i; push PCPlusF_o (pointer+1 mod RAS_DEPTH, write at new pointer); count+1 saturating at RAS_DEPTH.
  8. Otherwise → PCPlusF_o.
- RasHitF_o is asserted only in case 5, and only when no higher-priority condition holds.
- RAS overflow: a push when count==RAS_DEPTH overwrites the oldest entry (circular). Count stays at RAS_DEPTH.
- Arithmetic: all PC additions are unsigned modulo 2^DATA_WIDTH. 0xFFFFFFFC + 4 wraps to 0x00000000 with no flag. No alignment check.
- TrapE_i and PCsrcE_i together: trap wins.
- Redirect while StallF_i is asserted: the redirect is taken (redirects override stall).
- No other internal state exists. The block holds no recovery snapshot; a RAS corrupted by a mispredicted path is repaired only by a trap clear.

Test Plan:
- Reset then 3 free-running cycles → PC_o = 0xBFC00000, 0xBFC00004, 0xBFC00008; RasCount_o=0.
- StallF_i=1 for 2 cycles at PC 0xBFC00008, then PCsrcE_i=1 with PCTargetE_i=0xBFC00100 while still stalled → PC holds 2 cycles, then becomes 0xBFC00100.
- Call at PC 0x1000 (target 0x2000), then Ret at 0x2010 → PC goes 0x2000, then 0x1004 with RasHitF_o=1; RasCount_o goes 1, then 0.
- Five nested calls with RAS_DEPTH=4 from PCs 0x100, 0x200, 0x300, 0x400, 0x500, then five returns → first four returns hit 0x504, 0x404, 0x304, 0x204. Fifth return has RasHitF_o=0 and goes sequential.
- TrapE_i=1, PCsrcE_i=1 and CallF_i=1 in the same cycle with RasCount_o=3 → PC_o=0xBFC00380; RasCount_o=0.
- PC=0xFFFFFFFC, no events → PC_o=0x00000000. Mid-operation rst with RasCount_o=2 → PC_o=0xBFC00000, RasCount_o=0 on the next edge.
